twi_motor_regs: RTL and testbench
=================================

# twi_motor_regs

Parametrised motor-speed register bank for the I2C-controlled motor path. It takes byte writes from a `twi_slave2` register port and keeps CHANNELS signed speed setpoints, committed atomically. Outputs are ramped toward their targets with a bounded slew rate, and a command watchdog forces all targets to zero when the host stops refreshing. It sits between the speed `twi_slave2` instance and the motor driver(s), replacing hand-written per-channel address decoding in `top`.

## Interface
- CHANNELS, 2: number of speed channels, 1..16; channel n lives at register address n.
- STEP, 4: magnitude added to or subtracted from an output per ramp tick, 1..127.
- RAMP_DIV, 16000: clocks per ramp tick (1 ms at 16 MHz), ≥2.
- TIMEOUT, 8000000: clocks without a commit before the watchdog trips (0.5 s at 16 MHz), ≥2.

- clk  in  1  system clock (clk_16mhz domain).
- rst_n  in  1  asynchronous, active-low reset.
- reg_addr  in  8  register address from `twi_slave2`; stable while reg_wclk is high.
- reg_wdata  in  8  write data from `twi_slave2`; stable while reg_wclk is high.
- reg_wclk  in  1  write strobe (`dataInClk`), SCL-domain, asynchronous to clk.
- reg_rdata  out  8  read data for reg_addr (combinational).
- speed_out  out  8*CHANNELS  ramped signed speeds; channel n is [8n+7:8n].
- alive_tick  out  1  toggles on every commit (for the driver's `aliveStrobe`).
- timed_out  out  1  watchdog tripped.
- settled  out  1  every output equals its effective target.

## Operation
- **Write strobe handling:**
  - reg_wclk passes through a 2-flop synchronizer.
  - A rising edge on the synchronized signal is a write event (1 clk pulse).
  - reg_addr and reg_wdata are sampled on that pulse.
- **Address map (write):**
  - 0x00..CHANNELS-1: shadow[n] ← wdata. A write of 0x80 (-128) is clamped to 0x81 (-127).
  - Write to CHANNELS-1 = commit: every target ← shadow (including the new value), alive_tick toggles, watchdog counter cleared, timed_out cleared.
  - 0x80 control: bit0 enable; bit1 brake (self-clearing, reads 0). Other bits ignored.
  - All other addresses: ignored.
- **Address map (read):**
  - 0x00..CHANNELS-1: target[n].
  - 0x80: {7'b0, enable}.
  - 0x81: {6'b0, settled, timed_out}.
  - 0xF0: CHANNELS.
  - Anything else: 0xFF.
- **Effective target** is 0 when enable=0 or timed_out=1; otherwise target[n].
- **Ramp:** a prescaler counts 0..RAMP_DIV-1 and a tick fires on wrap. On each tick, per channel, with diff = eff_target - out computed in 9-bit signed:
  - |diff| ≤ STEP: out ← eff_target.
  - Otherwise out moves STEP toward eff_target.
  - Never overshoots, never wraps.
- **Brake:** speed_out ← 0 for all channels on the write cycle. Targets are unchanged and ramping resumes from 0.
- **Watchdog:** the counter increments every clk while timed_out=0 and saturates. At TIMEOUT-1 → timed_out=1, and stays set until the next commit.
- **State:** the watchdog FSM has two states, RUN and TRIPPED.
  - RUN → TRIPPED on counter = TIMEOUT-1 with no commit that cycle.
  - TRIPPED → RUN on commit.
- **Reset values:**
  - shadow, target, and speed_out all 0.
  - enable=1, alive_tick=0, timed_out=0, settled=1.
  - prescaler and watchdog counter 0.

## Timing
- **Write latency:** the register update is visible at the clk edge 3 cycles after reg_wclk rises (2 sync flops + edge register). reg_rdata reflects the update that same cycle.
- **First ramp movement:** at most RAMP_DIV clocks after a commit.
- **Full-scale traversal:** -127→127 takes ceil(254/STEP) ticks.
- **Commit and ramp tick in the same cycle:** the step uses the pre-commit targets. New targets apply from the next tick.
- **Commit and watchdog trip in the same cycle:** commit wins; timed_out stays 0 and the counter is cleared.
- **Brake and ramp tick in the same cycle:** brake wins; outputs are 0.
- **Brake and commit in the same cycle:** not possible, since they use different addresses.
- **Disabled channels:** enable=0 ramps outputs to 0 (not an instant drop). Writes and commits still update targets and the watchdog.
- **Strobe glitches:** strobes shorter than 2 clk periods may be missed. The I2C strobe is ≥ several µs, so this is not a constraint.
- **Mid-operation reset:** rst_n low mid-ramp or mid-write → all state returns to its reset value immediately (asynchronous). A write strobe already high at deassertion is not treated as an edge.
- **settled:** registered, so it lags the outputs by 1 clk.

## Test plan
- **Reset values:** assert rst_n=0 with reg_wclk=1, then release.
  - speed_out=0, settled=1, timed_out=0, enable=1.
  - No write occurs until reg_wclk falls and rises again.
- **Atomic commit:** CHANNELS=2, STEP=4, RAMP_DIV=4.
  - Write 0x00←0x14; speed_out stays 0 and alive_tick stays 0.
  - Write 0x01←0xEC; alive_tick=1.
  - Ch0 steps 4,8,12,16,20 and ch1 steps -4..-20 on consecutive ticks; then settled=1.
- **No overshoot and clamp:** STEP=4.
  - Target 0x06 from 0 → outputs 4 then 6.
  - Write 0x80 to ch0 → reads back 0x81; output ramps to -127 and does not wrap.
- **Watchdog:** TIMEOUT=100.
  - Commit 50/50 and wait 100 clk → timed_out=1 and outputs ramp to 0.
  - Commit again → timed_out=0 and outputs ramp back to 50.
  - Commit exactly at count 99 → timed_out never asserts.
- **Brake and enable:**
  - Outputs at 40: write 0x80←0x03 → outputs 0 on the update cycle, then ramp back toward 40. Reading 0x80 returns 0x01.
  - Write 0x80←0x00 → outputs ramp to 0; ch reads still return 40.
- **Read map:**
  - Read 0xF0 → CHANNELS.
  - Read 0x81 → {settled, timed_out}.
  - Read 0x42 → 0xFF.
  - Write 0x42 → no state change and no alive_tick toggle.

Source files
------------

// File: rtl/twi_motor_regs.sv
// Motor speed register bank fed by twi_slave2 byte writes. Setpoints are committed atomically,
// outputs are slew-limited toward them, and a watchdog zeroes targets when commits stop.
module twi_motor_regs #(
   parameter int CHANNELS = 2,
   parameter int STEP     = 4,
   parameter int RAMP_DIV = 16000,
   parameter int TIMEOUT  = 8000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            reg_addr,
   input  logic [7:0]            reg_wdata,
   input  logic                  reg_wclk,
   output logic [7:0]            reg_rdata,
   output logic [8*CHANNELS-1:0] speed_out,
   output logic                  alive_tick,
   output logic                  timed_out,
   output logic                  settled
);

   localparam int                PRE_W       = $clog2(RAMP_DIV);
   localparam int                WD_W        = $clog2(TIMEOUT);
   localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_W'(RAMP_DIV - 1);
   localparam logic [PRE_W-1:0]  PRE_ONE     = PRE_W'(1);
   localparam logic [WD_W-1:0]   WD_LAST     = WD_W'(TIMEOUT - 1);
   localparam logic [WD_W-1:0]   WD_ONE      = WD_W'(1);
   localparam logic [7:0]        COMMIT_ADDR = 8'(CHANNELS - 1);
   localparam logic [7:0]        NCHAN_BYTE  = 8'(CHANNELS);
   localparam logic [7:0]        CTRL_ADDR   = 8'h80;
   localparam logic [7:0]        STAT_ADDR   = 8'h81;
   localparam logic [7:0]        ID_ADDR     = 8'hF0;
   localparam logic [7:0]        STEP_B      = 8'(STEP);
   localparam logic signed [8:0] STEP_S      = 9'(STEP);

   typedef enum logic {WD_RUN = 1'b0, WD_TRIPPED = 1'b1} wd_state_t;

   // -128 has no positive counterpart, so it is stored as -127 to keep ramps symmetric
   function automatic logic [7:0] clamp_speed(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h80) r = 8'h81;
      else            r = v;
      return r;
   endfunction

   function automatic logic [7:0] ramp_step(input logic [7:0] cur, input logic [7:0] tgt);
      logic signed [8:0] diff;
      logic [7:0]        r;
      diff = $signed({tgt[7], tgt}) - $signed({cur[7], cur});
      if (diff > STEP_S)       r = cur + STEP_B;
      else if (diff < -STEP_S) r = cur - STEP_B;
      else                     r = tgt;
      return r;
   endfunction

   logic             wclk_meta_r, wclk_sync_r, wclk_prev_r;
   logic             wr_pulse_s, commit_s, ctrl_wr_s, brake_s, tick_s, all_settled_s;
   logic [7:0]       wdata_clamped_s;
   logic [PRE_W-1:0] pre_r;
   logic [WD_W-1:0]  wd_cnt_r;
   wd_state_t        wd_state_r, wd_state_s;
   logic             enable_r, alive_r, settled_r;
   logic [7:0]       shadow_r [CHANNELS];
   logic [7:0]       target_r [CHANNELS];
   logic [7:0]       out_r    [CHANNELS];
   logic [7:0]       eff_s    [CHANNELS];
   logic [7:0]       rd_tbl_s [16];

   // Strobe synchronizer; preset high so a strobe already high at reset release is not an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wclk_meta_r <= 1'b1;
         wclk_sync_r <= 1'b1;
         wclk_prev_r <= 1'b1;
      end else begin
         wclk_meta_r <= reg_wclk;
         wclk_sync_r <= wclk_meta_r;
         wclk_prev_r <= wclk_sync_r;
      end
   end

   assign wr_pulse_s      = wclk_sync_r & ~wclk_prev_r;
   assign wdata_clamped_s = clamp_speed(reg_wdata);
   assign commit_s        = wr_pulse_s && (reg_addr == COMMIT_ADDR);
   assign ctrl_wr_s       = wr_pulse_s && (reg_addr == CTRL_ADDR);
   assign brake_s         = ctrl_wr_s && reg_wdata[1];
   assign tick_s          = (pre_r == PRE_LAST);
   assign timed_out       = (wd_state_r == WD_TRIPPED);

   // Effective targets and the all-channels-settled condition
   always_comb begin
      all_settled_s = 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
         if (enable_r && !timed_out) eff_s[i] = target_r[i];
         else                        eff_s[i] = 8'h00;
         all_settled_s = all_settled_s & (out_r[i] == eff_s[i]);
      end
   end

   // Shadow, committed targets and ramped outputs; brake overrides a coincident tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_r[i] <= 8'h00;
            target_r[i] <= 8'h00;
            out_r[i]    <= 8'h00;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (wr_pulse_s && (reg_addr == 8'(i))) shadow_r[i] <= wdata_clamped_s;
            if (commit_s) target_r[i] <= (i == CHANNELS - 1) ? wdata_clamped_s : shadow_r[i];
            if (brake_s)     out_r[i] <= 8'h00;
            else if (tick_s) out_r[i] <= ramp_step(out_r[i], eff_s[i]);
         end
      end
   end

   // Control bits, alive toggle, settled flag and ramp prescaler
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable_r  <= 1'b1;
         alive_r   <= 1'b0;
         settled_r <= 1'b1;
         pre_r     <= {PRE_W{1'b0}};
      end else begin
         if (ctrl_wr_s) enable_r <= reg_wdata[0];
         if (commit_s)  alive_r  <= ~alive_r;
         settled_r <= all_settled_s;
         if (tick_s) pre_r <= {PRE_W{1'b0}};
         else        pre_r <= pre_r + PRE_ONE;
      end
   end

   // Watchdog state and saturating counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_state_r <= WD_RUN;
         wd_cnt_r   <= {WD_W{1'b0}};
      end else begin
         wd_state_r <= wd_state_s;
         if (commit_s) wd_cnt_r <= {WD_W{1'b0}};
         else if ((wd_state_r == WD_RUN) && (wd_cnt_r != WD_LAST)) wd_cnt_r <= wd_cnt_r + WD_ONE;
      end
   end

   // Watchdog next state; a commit always wins over an expiring count
   always_comb begin
      wd_state_s = wd_state_r;
      case (wd_state_r)
         WD_RUN: begin
            if (commit_s)                wd_state_s = WD_RUN;
            else if (wd_cnt_r == WD_LAST) wd_state_s = WD_TRIPPED;
            else                         wd_state_s = WD_RUN;
         end
         WD_TRIPPED: begin
            if (commit_s) wd_state_s = WD_RUN;
            else          wd_state_s = WD_TRIPPED;
         end
         default: wd_state_s = WD_RUN;
      endcase
   end

   for (genvar g = 0; g < 16; g++) begin : g_rd
      if (g < CHANNELS) begin : g_ch
         assign rd_tbl_s[g] = target_r[g];
      end else begin : g_pad
         assign rd_tbl_s[g] = 8'hFF;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_out
      assign speed_out[8*g +: 8] = out_r[g];
   end

   // Combinational read mux
   always_comb begin
      reg_rdata = 8'hFF;
      if (reg_addr < NCHAN_BYTE) begin
         reg_rdata = rd_tbl_s[reg_addr[3:0]];
      end else begin
         case (reg_addr)
            CTRL_ADDR: reg_rdata = {7'b0, enable_r};
            STAT_ADDR: reg_rdata = {6'b0, settled_r, timed_out};
            ID_ADDR:   reg_rdata = NCHAN_BYTE;
            default:   reg_rdata = 8'hFF;
         endcase
      end
   end

   assign alive_tick = alive_r;
   assign settled    = settled_r;

endmodule

// File: tb/tb_twi_motor_regs.sv
// Directed bench for twi_motor_regs with CHANNELS=2, STEP=4, RAMP_DIV=4, TIMEOUT=100.
module tb_twi_motor_regs;

   logic        clk;
   logic        rst_n;
   logic [7:0]  reg_addr;
   logic [7:0]  reg_wdata;
   logic        reg_wclk;
   logic [7:0]  reg_rdata;
   logic [15:0] speed_out;
   logic        alive_tick;
   logic        timed_out;
   logic        settled;

   int n_checks = 0;
   int n_fail   = 0;
   logic exp_alive = 1'b0;
   int exp0 [8];
   int exp1 [8];

   twi_motor_regs #(.CHANNELS(2), .STEP(4), .RAMP_DIV(4), .TIMEOUT(100)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_wclk   (reg_wclk),
      .reg_rdata  (reg_rdata),
      .speed_out  (speed_out),
      .alive_tick (alive_tick),
      .timed_out  (timed_out),
      .settled    (settled)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ch0();
      return int'($signed(speed_out[7:0]));
   endfunction

   function automatic int ch1();
      return int'($signed(speed_out[15:8]));
   endfunction

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic strobe_write(input logic [7:0] addr, input logic [7:0] data);
      reg_addr  = addr;
      reg_wdata = data;
      reg_wclk  = 1'b1;
      if (addr == 8'h01) exp_alive = ~exp_alive;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
      strobe_write(addr, data);
      reg_wclk = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic rd_check(input string tag, input logic [7:0] addr, input int exp);
      reg_addr = addr;
      #1;
      check_eq(tag, int'(reg_rdata), exp);
   endtask

   task automatic wait_ch0(input string tag, input int val, input int budget);
      int n = 0;
      while (ch0() != val && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, ch0(), val);
   endtask

   task automatic track(input string tag, input int n, input int budget);
      int k = 0;
      int cyc = 0;
      int lastc = 0;
      int last;
      last = ch0();
      while (k < n && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (ch0() != last) begin
            check_eq({tag, "_ch0"}, ch0(), exp0[k]);
            check_eq({tag, "_ch1"}, ch1(), exp1[k]);
            if (k > 0) check_eq({tag, "_gap"}, cyc - lastc, 4);
            if (k == 0) check_eq({tag, "_settled_low"}, int'(settled), 0);
            last  = ch0();
            lastc = cyc;
            k++;
         end
      end
      check_eq({tag, "_steps"}, k, n);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      // Reset with the strobe already high and a commit address presented
      rst_n     = 1'b0;
      reg_wclk  = 1'b1;
      reg_addr  = 8'h01;
      reg_wdata = 8'h33;
      repeat (3) @(negedge clk);
      check_eq("in_reset_speed", int'(speed_out), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("rst_speed", int'(speed_out), 0);
      check_eq("rst_settled", int'(settled), 1);
      check_eq("rst_timed_out", int'(timed_out), 0);
      check_eq("rst_alive", int'(alive_tick), 0);
      rd_check("rst_target1", 8'h01, 0);
      rd_check("rst_enable", 8'h80, 1);
      reg_wclk = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_no_write", int'(alive_tick), 0);

      // Atomic commit
      do_write(8'h00, 8'h14);
      repeat (8) @(negedge clk);
      check_eq("shadow_no_move", int'(speed_out), 0);
      check_eq("shadow_no_alive", int'(alive_tick), 0);
      rd_check("shadow_not_target", 8'h00, 0);
      strobe_write(8'h01, 8'hEC);
      check_eq("commit_alive", int'(alive_tick), int'(exp_alive));
      for (int i = 0; i < 5; i++) begin
         exp0[i] = 4 * (i + 1);
         exp1[i] = -4 * (i + 1);
      end
      track("atomic", 5, 60);
      reg_wclk = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("atomic_settled", int'(settled), 1);
      rd_check("atomic_t0", 8'h00, 8'h14);
      rd_check("atomic_t1", 8'h01, 8'hEC);

      // No overshoot from 0 toward 6
      do_write(8'h00, 8'h00);
      do_write(8'h01, 8'h00);
      wait_ch0("back_to_zero", 0, 40);
      check_eq("back_to_zero_ch1", ch1(), 0);
      do_write(8'h00, 8'h06);
      strobe_write(8'h01, 8'h06);
      exp0[0] = 4; exp1[0] = 4;
      exp0[1] = 6; exp1[1] = 6;
      track("overshoot", 2, 40);
      reg_wclk = 1'b0;
      repeat (12) @(negedge clk);
      check_eq("overshoot_hold", ch0(), 6);

      // -128 clamp and full negative ramp without wrap
      do_write(8'h00, 8'h80);
      rd_check("clamp_uncommitted", 8'h00, 6);
      do_write(8'h01, 8'h06);
      rd_check("clamp_readback", 8'h00, 8'h81);
      for (int r = 0; r < 2; r++) begin
         repeat (40) @(negedge clk);
         do_write(8'h01, 8'h06);
      end
      wait_ch0("clamp_reach", -127, 120);
      repeat (8) @(negedge clk);
      check_eq("clamp_hold", ch0(), -127);
      check_eq("clamp_no_timeout", int'(timed_out), 0);

      // Watchdog trip, recovery and commit on the expiring cycle
      do_write(8'h00, 8'd50);
      do_write(8'h01, 8'd50);
      for (int r = 0; r < 3; r++) begin
         repeat (40) @(negedge clk);
         do_write(8'h01, 8'd50);
      end
      wait_ch0("wd_reach50", 50, 100);
      check_eq("wd_reach50_ch1", ch1(), 50);
      strobe_write(8'h01, 8'd50);
      repeat (99) @(negedge clk);
      check_eq("wd_before_trip", int'(timed_out), 0);
      @(negedge clk);
      check_eq("wd_trip", int'(timed_out), 1);
      rd_check("wd_status_lag", 8'h81, 3);
      @(negedge clk);
      rd_check("wd_status", 8'h81, 1);
      reg_wclk = 1'b0;
      wait_ch0("wd_ramp_zero", 0, 80);
      check_eq("wd_ramp_zero_ch1", ch1(), 0);
      check_eq("wd_still_tripped", int'(timed_out), 1);
      strobe_write(8'h01, 8'd50);
      check_eq("wd_cleared", int'(timed_out), 0);
      reg_wclk = 1'b0;
      wait_ch0("wd_resume50", 50, 80);
      strobe_write(8'h01, 8'd50);
      reg_wclk = 1'b0;
      repeat (97) @(negedge clk);
      strobe_write(8'h01, 8'd50);
      check_eq("wd_commit_wins", int'(timed_out), 0);
      reg_wclk = 1'b0;
      repeat (10) @(negedge clk);
      check_eq("wd_commit_wins_later", int'(timed_out), 0);
      check_eq("wd_alive", int'(alive_tick), int'(exp_alive));

      // Brake and enable
      do_write(8'h00, 8'd40);
      do_write(8'h01, 8'd40);
      wait_ch0("brake_pre40", 40, 40);
      strobe_write(8'h80, 8'h03);
      check_eq("brake_ch0", ch0(), 0);
      check_eq("brake_ch1", ch1(), 0);
      rd_check("brake_ctrl_read", 8'h80, 1);
      reg_wclk = 1'b0;
      wait_ch0("brake_resume", 40, 60);
      check_eq("brake_resume_ch1", ch1(), 40);
      do_write(8'h01, 8'd40);
      do_write(8'h80, 8'h00);
      wait_ch0("disable_ramp0", 0, 60);
      check_eq("disable_ch1", ch1(), 0);
      check_eq("disable_no_timeout", int'(timed_out), 0);
      rd_check("disable_t0", 8'h00, 40);
      rd_check("disable_t1", 8'h01, 40);
      rd_check("disable_ctrl", 8'h80, 0);
      do_write(8'h80, 8'h01);

      // Read map and ignored write
      repeat (150) @(negedge clk);
      rd_check("rd_id", 8'hF0, 2);
      rd_check("rd_status", 8'h81, 3);
      rd_check("rd_unmapped", 8'h42, 8'hFF);
      do_write(8'h42, 8'h55);
      check_eq("ign_alive", int'(alive_tick), int'(exp_alive));
      check_eq("ign_timed_out", int'(timed_out), 1);
      rd_check("ign_t0", 8'h00, 40);
      rd_check("ign_t1", 8'h01, 40);
      rd_check("ign_enable", 8'h80, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
